bubble_sort_engine: RTL and testbench
=====================================

BUBBLE_SORT_ENGINE -- requirements
Module: bubble_sort_engine

Interface
REQ-001 Parameter MAX_COUNT, default 64, maximum element count accepted.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 base_addr  input  64  byte address of element 0; 8-byte aligned.
REQ-006 count  input  8  element count; values above MAX_COUNT clamp to MAX_COUNT.
REQ-007 Mem_Addr  output  64  byte address to data memory.
REQ-008 WriteData  output  64  doubleword to write.
REQ-009 MemWrite  output  1  write strobe; memory commits on the rising edge.
REQ-010 MemRead  output  1  read enable.
REQ-011 ReadData  input  64  combinational read data, valid in the same cycle as Mem_Addr/MemRead.
REQ-012 busy  output  1  high from the cycle after an accepted start until DONE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 swaps  output  16  swaps performed in the current or last sort.

Function
REQ-015 Elements are 64-bit little-endian doublewords at base_addr + 8*k; sort is ascending by signed 64-bit compare.
REQ-016 States: IDLE, LOAD_A, LOAD_B, STORE_A, STORE_B, ADV, DONE.
REQ-017 IDLE with start=1: latch base_addr and clamped count, clear swaps, set j=0 and limit=count; go to LOAD_A if count>=2, else DONE.
REQ-018 LOAD_A: MemRead=1, Mem_Addr=base+8*j; capture ReadData into a_reg.
REQ-019 LOAD_B: MemRead=1, Mem_Addr=base+8*(j+1); capture ReadData into b_reg; go to STORE_A if a_reg > ReadData (signed), else ADV.
REQ-020 STORE_A: MemWrite=1, Mem_Addr=base+8*j, WriteData=b_reg; set pass_swapped; increment swaps (saturating at 0xFFFF).
REQ-021 STORE_B: MemWrite=1, Mem_Addr=base+8*(j+1), WriteData=a_reg; go to ADV.
REQ-022 ADV: if j+2 < limit, increment j and go to LOAD_A.
REQ-023 ADV at end of pass: go to DONE if limit==2 (or the early-exit condition of REQ-030 holds); otherwise decrement limit, clear j and pass_swapped, and go to LOAD_A.
REQ-024 DONE: done=1 for exactly one cycle, busy=0, next state IDLE.
REQ-025 MemRead and MemWrite are never both high; both are low in IDLE, ADV and DONE.
REQ-026 Mem_Addr and WriteData hold their last values when the strobes are low.
REQ-027 start during any non-IDLE state is ignored; start in IDLE in the DONE-exit cycle is accepted.
REQ-028 Per-pair cost is 3 cycles without a swap and 5 cycles with a swap.

Reset
REQ-029 While reset=0, state=IDLE, and Mem_Addr, WriteData, MemWrite, MemRead, busy, done, swaps and all counters are 0. A reset mid-sort abandons the sort, leaves memory as last written, and generates no done pulse.

Configuration
REQ-030 Macro SORT_EARLY_EXIT_EN defined: ADV at end of pass also goes to DONE when pass_swapped=0. Undefined: always execute count-1 passes.

Structure
REQ-031 Package sort_pkg holds the state enum, DWORD_BYTES=8 and the swaps width constant.
REQ-032 One sub-module is natural: sort_cmp (signed a>b decision).

Verification
REQ-033 Memory {8,6,1,9,2} at base 0, count=5 -> memory {1,2,6,8,9}, swaps=6, single done pulse.
REQ-034 Sorted {1,2,3,4,5}, SORT_EARLY_EXIT_EN defined -> done after one pass (12 busy cycles), swaps=0; without the macro, 4 passes, memory unchanged.
REQ-035 count=1 or count=0 -> done the cycle after the start cycle, no MemRead/MemWrite, swaps=0.
REQ-036 {0x0000000000000001, 0xFFFFFFFFFFFFFFFF} at base 0x10 -> swapped to {-1, 1}, swaps=1, addresses 0x10/0x18 only.
REQ-037 reset asserted during STORE_A -> all outputs 0 immediately, IDLE, no done; a new start then sorts correctly.
REQ-038 start pulsed while busy -> ignored, result identical to an uninterrupted run.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and constants for the in-memory bubble sort engine.
package sort_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    STORE_A,
    STORE_B,
    ADV,
    DONE
  } state_t;

  localparam int DWORD_BYTES = 8;
  localparam int SWAPS_W     = 16;

  // Byte address of element idx in an array of doublewords starting at base.
  function automatic logic [63:0] elem_addr(input logic [63:0] base, input logic [7:0] idx);
    return base + (64'(idx) * 64'(DWORD_BYTES));
  endfunction

endpackage

// File: rtl/sort_cmp.sv
// Signed 64-bit greater-than decision used to decide whether a pair must swap.
module sort_cmp (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        gt
);

  assign gt = $signed(a) > $signed(b);

endmodule

// File: rtl/bubble_sort_engine.sv
// Bubble sort of signed 64-bit doublewords held in an external single-port memory.
// Optional macro SORT_EARLY_EXIT_EN: stop after the first pass that performs no swap.
module bubble_sort_engine
  import sort_pkg::*;
#(
  parameter int MAX_COUNT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [63:0]        base_addr,
  input  logic [7:0]         count,
  output logic [63:0]        Mem_Addr,
  output logic [63:0]        WriteData,
  output logic               MemWrite,
  output logic               MemRead,
  input  logic [63:0]        ReadData,
  output logic               busy,
  output logic               done,
  output logic [SWAPS_W-1:0] swaps
);

  localparam logic [7:0] MAX_CNT8 = 8'(MAX_COUNT);

  state_t             state_reg, state_next;
  logic [63:0]        base_reg, a_reg, b_reg;
  logic [63:0]        addr_hold_reg, wdata_hold_reg;
  logic [63:0]        addr_cur, wdata_cur;
  logic [7:0]         j_reg, limit_reg, count_clamped;
  logic [SWAPS_W-1:0] swaps_reg;
  logic               a_gt_b, pass_end, last_pass;
`ifdef SORT_EARLY_EXIT_EN
  logic               pass_swapped_reg;
`endif

  sort_cmp u_cmp (
    .a  (a_reg),
    .b  (ReadData),
    .gt (a_gt_b)
  );

  assign count_clamped = (count > MAX_CNT8) ? MAX_CNT8 : count;
  assign pass_end      = !(({1'b0, j_reg} + 9'd2) < {1'b0, limit_reg});
`ifdef SORT_EARLY_EXIT_EN
  assign last_pass     = (limit_reg == 8'd2) || !pass_swapped_reg;
`else
  assign last_pass     = (limit_reg == 8'd2);
`endif

  always_comb begin
    state_next = state_reg;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    addr_cur   = addr_hold_reg;
    wdata_cur  = wdata_hold_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = (count_clamped >= 8'd2) ? LOAD_A : DONE;
      end
      LOAD_A: begin
        MemRead    = 1'b1;
        addr_cur   = elem_addr(base_reg, j_reg);
        state_next = LOAD_B;
      end
      LOAD_B: begin
        MemRead    = 1'b1;
        addr_cur   = elem_addr(base_reg, j_reg + 8'd1);
        state_next = a_gt_b ? STORE_A : ADV;
      end
      STORE_A: begin
        MemWrite   = 1'b1;
        addr_cur   = elem_addr(base_reg, j_reg);
        wdata_cur  = b_reg;
        state_next = STORE_B;
      end
      STORE_B: begin
        MemWrite   = 1'b1;
        addr_cur   = elem_addr(base_reg, j_reg + 8'd1);
        wdata_cur  = a_reg;
        state_next = ADV;
      end
      ADV: begin
        if (!pass_end)     state_next = LOAD_A;
        else if (last_pass) state_next = DONE;
        else               state_next = LOAD_A;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address/data outputs hold their last driven value while the strobes are idle.
  assign Mem_Addr  = addr_cur;
  assign WriteData = wdata_cur;
  assign busy      = (state_reg != IDLE) && (state_reg != DONE);
  assign done      = (state_reg == DONE);
  assign swaps     = swaps_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      base_reg         <= '0;
      a_reg            <= '0;
      b_reg            <= '0;
      addr_hold_reg    <= '0;
      wdata_hold_reg   <= '0;
      j_reg            <= '0;
      limit_reg        <= '0;
      swaps_reg        <= '0;
`ifdef SORT_EARLY_EXIT_EN
      pass_swapped_reg <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      addr_hold_reg  <= addr_cur;
      wdata_hold_reg <= wdata_cur;
      case (state_reg)
        IDLE: begin
          if (start) begin
            base_reg         <= base_addr;
            limit_reg        <= count_clamped;
            j_reg            <= '0;
            swaps_reg        <= '0;
`ifdef SORT_EARLY_EXIT_EN
            pass_swapped_reg <= 1'b0;
`endif
          end
        end
        LOAD_A: a_reg <= ReadData;
        LOAD_B: b_reg <= ReadData;
        STORE_A: begin
`ifdef SORT_EARLY_EXIT_EN
          pass_swapped_reg <= 1'b1;
`endif
          if (swaps_reg != '1) swaps_reg <= swaps_reg + 1'b1;
        end
        ADV: begin
          if (!pass_end) begin
            j_reg <= j_reg + 8'd1;
          end else if (!last_pass) begin
            limit_reg        <= limit_reg - 8'd1;
            j_reg            <= '0;
`ifdef SORT_EARLY_EXIT_EN
            pass_swapped_reg <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Directed bench for bubble_sort_engine against a behavioural doubleword memory.
module tb_bubble_sort_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] base_addr;
  logic [7:0]  count;
  logic [63:0] Mem_Addr, WriteData, ReadData;
  logic        MemWrite, MemRead, busy, done;
  logic [15:0] swaps;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  logic [63:0] mem [0:127];
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, busy_cnt = 0, both_cnt = 0, bad_cnt = 0;
  logic [63:0] lo_addr = 0, hi_addr = 0;

  bubble_sort_engine dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .Mem_Addr  (Mem_Addr),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .ReadData  (ReadData),
    .busy      (busy),
    .done      (done),
    .swaps     (swaps)
  );

  always #5 clk = ~clk;

  assign ReadData = mem[Mem_Addr[9:3]];

  // Memory commits on the rising edge; activity counters see pre-edge values.
  always @(posedge clk) begin
    if (MemWrite) mem[Mem_Addr[9:3]] = WriteData;
    if (MemRead) rd_cnt = rd_cnt + 1;
    if (MemWrite) wr_cnt = wr_cnt + 1;
    if (MemRead && MemWrite) both_cnt = both_cnt + 1;
    if ((MemRead || MemWrite) && (Mem_Addr < lo_addr || Mem_Addr >= hi_addr)) bad_cnt = bad_cnt + 1;
    if (done) done_cnt = done_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int busy_d, rd_d, wr_d, done_d, bad_d, both_d;

  task automatic run_sort(input logic [63:0] b, input logic [7:0] c, input bit poke);
    int s_busy, s_rd, s_wr, s_done, s_bad, s_both, n, eff;
    s_busy = busy_cnt; s_rd = rd_cnt; s_wr = wr_cnt;
    s_done = done_cnt; s_bad = bad_cnt; s_both = both_cnt;
    eff = (c > 8'd64) ? 64 : int'(c);
    lo_addr = b;
    hi_addr = b + 64'(8 * eff);
    @(negedge clk);
    start = 1'b1; base_addr = b; count = c;
    @(negedge clk);
    start = 1'b0; base_addr = 64'hDEAD_0000; count = 8'd3;
    if (c < 8'd2) check_val("done_next_cycle", {63'd0, done}, 64'd1);
    n = 0;
    while (!done && n < 20000) begin
      start = (poke && (n == 7 || n == 15)) ? 1'b1 : 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (!done) check_val("done_timeout", 64'd0, 64'd1);
    repeat (3) @(negedge clk);
    busy_d = busy_cnt - s_busy; rd_d = rd_cnt - s_rd; wr_d = wr_cnt - s_wr;
    done_d = done_cnt - s_done; bad_d = bad_cnt - s_bad; both_d = both_cnt - s_both;
    $display("sort base=%h count=%0d busy_cycles=%0d reads=%0d writes=%0d swaps=%0d",
             b, c, busy_d, rd_d, wr_d, swaps);
  endtask

  task automatic check_common(input string tag, input int exp_swaps);
    check_val({tag, "_swaps"}, 64'(swaps), 64'(exp_swaps));
    check_val({tag, "_done_pulses"}, 64'(done_d), 64'd1);
    check_val({tag, "_bad_addr"}, 64'(bad_d), 64'd0);
    check_val({tag, "_rd_wr_overlap"}, 64'(both_d), 64'd0);
  endtask

  task automatic load_unsorted();
    mem[0] = 64'd8; mem[1] = 64'd6; mem[2] = 64'd1; mem[3] = 64'd9; mem[4] = 64'd2;
  endtask

  task automatic check_unsorted_result(input string tag);
    check_val({tag, "_m0"}, mem[0], 64'd1);
    check_val({tag, "_m1"}, mem[1], 64'd2);
    check_val({tag, "_m2"}, mem[2], 64'd6);
    check_val({tag, "_m3"}, mem[3], 64'd8);
    check_val({tag, "_m4"}, mem[4], 64'd9);
    check_val({tag, "_busy"}, 64'(busy_d), 64'd42);
    check_val({tag, "_reads"}, 64'(rd_d), 64'd20);
    check_val({tag, "_writes"}, 64'(wr_d), 64'd12);
    check_common(tag, 6);
  endtask

  initial begin
    int n;
    int s_done;
    for (int i = 0; i < 128; i++) mem[i] = 64'h5A00 + 64'(i);
    reset = 1'b0; start = 1'b0; base_addr = '0; count = '0;
    repeat (2) @(negedge clk);
    check_val("rst_addr", Mem_Addr, 64'd0);
    check_val("rst_wdata", WriteData, 64'd0);
    check_val("rst_memwrite", {63'd0, MemWrite}, 64'd0);
    check_val("rst_memread", {63'd0, MemRead}, 64'd0);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_done", {63'd0, done}, 64'd0);
    check_val("rst_swaps", 64'(swaps), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    load_unsorted();
    run_sort(64'd0, 8'd5, 1'b0);
    check_unsorted_result("unsorted5");

    run_sort(64'd0, 8'd0, 1'b0);
    check_val("cnt0_busy", 64'(busy_d), 64'd0);
    check_val("cnt0_access", 64'(rd_d + wr_d), 64'd0);
    check_common("cnt0", 0);

    for (int i = 0; i < 5; i++) mem[i] = 64'(i + 1);
    run_sort(64'd0, 8'd5, 1'b0);
`ifdef SORT_EARLY_EXIT_EN
    check_val("sorted5_busy", 64'(busy_d), 64'd12);
`else
    check_val("sorted5_busy", 64'(busy_d), 64'd30);
`endif
    check_val("sorted5_writes", 64'(wr_d), 64'd0);
    for (int i = 0; i < 5; i++) check_val($sformatf("sorted5_m%0d", i), mem[i], 64'(i + 1));
    check_common("sorted5", 0);

    run_sort(64'd0, 8'd1, 1'b0);
    check_val("cnt1_busy", 64'(busy_d), 64'd0);
    check_val("cnt1_access", 64'(rd_d + wr_d), 64'd0);
    check_common("cnt1", 0);

    mem[1] = 64'h1111; mem[2] = 64'd1; mem[3] = 64'hFFFF_FFFF_FFFF_FFFF; mem[4] = 64'h4444;
    run_sort(64'h10, 8'd2, 1'b0);
    check_val("signed_m2", mem[2], 64'hFFFF_FFFF_FFFF_FFFF);
    check_val("signed_m3", mem[3], 64'd1);
    check_val("signed_m1_untouched", mem[1], 64'h1111);
    check_val("signed_m4_untouched", mem[4], 64'h4444);
    check_val("signed_busy", 64'(busy_d), 64'd5);
    check_common("signed", 1);

    // Abort a sort while its first store is on the bus.
    mem[0] = 64'd5; mem[1] = 64'd3;
    lo_addr = 64'd0; hi_addr = 64'd16;
    s_done = done_cnt;
    @(negedge clk);
    start = 1'b1; base_addr = 64'd0; count = 8'd2;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!MemWrite && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("abort_store_a_reached", {63'd0, MemWrite}, 64'd1);
    check_val("abort_store_a_data", WriteData, 64'd3);
    reset = 1'b0;
    #1;
    check_val("abort_addr", Mem_Addr, 64'd0);
    check_val("abort_wdata", WriteData, 64'd0);
    check_val("abort_strobes", {62'd0, MemWrite, MemRead}, 64'd0);
    check_val("abort_busy", {63'd0, busy}, 64'd0);
    check_val("abort_swaps", 64'(swaps), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("abort_no_done", 64'(done_cnt - s_done), 64'd0);
    check_val("abort_mem_unchanged", mem[0], 64'd5);
    run_sort(64'd0, 8'd2, 1'b0);
    check_val("resort_m0", mem[0], 64'd3);
    check_val("resort_m1", mem[1], 64'd5);
    check_common("resort", 1);

    load_unsorted();
    run_sort(64'd0, 8'd5, 1'b1);
    check_unsorted_result("poked5");

    // Count above MAX_COUNT: only the first 64 elements may be touched.
    for (int i = 0; i < 64; i++) mem[i] = 64'(i);
    mem[64] = 64'hFFFF_FFFF_FFFF_FFFB;
    run_sort(64'd0, 8'd200, 1'b0);
`ifdef SORT_EARLY_EXIT_EN
    check_val("clamp_busy", 64'(busy_d), 64'd189);
`else
    check_val("clamp_busy", 64'(busy_d), 64'd6048);
`endif
    check_val("clamp_sentinel", mem[64], 64'hFFFF_FFFF_FFFF_FFFB);
    check_val("clamp_m63", mem[63], 64'd63);
    check_common("clamp", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
